// File: rtl/video_in_ctrl_pkg.sv
// Shared types for the video-in capture controller: FSM states, capture status codes
// and the default frame geometry.
package video_in_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      SYNC    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SIZE    = 2'b01,
      ST_ABORT   = 2'b10,
      ST_TIMEOUT = 2'b11
   } status_t;

   localparam int FRAME_PIXELS_DEF = 320 * 240;

   // Final status of a frame that ended on EOP: any size or framing error reports 01.
   function automatic status_t eop_status(input logic i_size_err);
      return i_size_err ? ST_SIZE : ST_OK;
   endfunction

endpackage

// File: rtl/video_in_watchdog.sv
// Cycle watchdog: cleared by i_load, counts while i_en, flags o_expire on the
// LIMIT-th enabled cycle so the owner can act on that same edge.
module video_in_watchdog #(
   parameter int LIMIT = 2**22
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/video_frame_capture_ctrl.sv
// Single-frame capture sequencer for the video-in stream pipeline (flush, SOP sync,
// pixel counting, status). Optional watchdog enabled by defining VFCC_TIMEOUT_EN.
module video_frame_capture_ctrl
   import video_in_ctrl_pkg::*;
#(
   parameter int FRAME_PIXELS  = FRAME_PIXELS_DEF,
   parameter int PIX_CNT_W     = 24,
   parameter int SRESET_CYCLES = 4,
   parameter int FRM_CNT_W     = 16
`ifdef VFCC_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 2**22
`endif
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 capture_req,
   input  logic                 capture_abort,
   input  logic                 stream_valid,
   input  logic                 stream_startofpacket,
   input  logic                 stream_control_endofpacket,
   output logic                 stream_control_ready,
   output logic                 stream_control_sreset,
   output logic                 capture_busy,
   output logic                 capture_done,
   output logic [1:0]           capture_status,
   output logic [PIX_CNT_W-1:0] pixel_count,
   output logic [FRM_CNT_W-1:0] frame_count
);

   localparam int                   FLUSH_W    = $clog2(SRESET_CYCLES + 1);
   localparam logic [FLUSH_W-1:0]   FLUSH_LOAD = FLUSH_W'(SRESET_CYCLES - 1);
   localparam logic [PIX_CNT_W-1:0] FRAME_LEN  = PIX_CNT_W'(FRAME_PIXELS);

   state_t                 r_state;
   status_t                r_status;
   logic [FLUSH_W-1:0]     r_flush_cnt;
   logic                   r_ready;
   logic                   r_sreset;
   logic                   r_busy;
   logic                   r_done;
   logic [PIX_CNT_W-1:0]   r_pix_cnt;
   logic [FRM_CNT_W-1:0]   r_frm_cnt;

   logic                   w_accept;
   logic                   w_in_frame;
   logic                   w_take;
   logic                   w_end;
   logic                   w_restart;
   logic                   w_size_err;
   logic                   w_timeout;
   logic [PIX_CNT_W-1:0]   w_pix_new;

   assign w_accept   = stream_valid & r_ready;
   assign w_in_frame = (r_state == CAPTURE);
   // In SYNC only an SOP beat is taken; in CAPTURE every accepted beat counts.
   assign w_take     = w_accept & (w_in_frame | stream_startofpacket);
   assign w_end      = w_take & stream_control_endofpacket;
   assign w_restart  = w_in_frame & stream_startofpacket;

   always_comb begin
      w_pix_new = r_pix_cnt;
      if (!w_in_frame || stream_startofpacket) begin
         w_pix_new = PIX_CNT_W'(1);
      end else if (r_pix_cnt != {PIX_CNT_W{1'b1}}) begin
         w_pix_new = r_pix_cnt + 1'b1;
      end
   end

   assign w_size_err = (r_status == ST_SIZE) | w_restart | (w_pix_new != FRAME_LEN);

`ifdef VFCC_TIMEOUT_EN
   video_in_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (clk_clk),
      .i_rst_n  (reset_reset_n),
      .i_load   ((r_state == IDLE) && capture_req),
      .i_en     ((r_state == SYNC) || (r_state == CAPTURE)),
      .o_expire (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state     <= IDLE;
         r_status    <= ST_OK;
         r_flush_cnt <= '0;
         r_ready     <= 1'b0;
         r_sreset    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pix_cnt   <= '0;
         r_frm_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (capture_req) begin
                  r_state     <= FLUSH;
                  r_sreset    <= 1'b1;
                  r_busy      <= 1'b1;
                  r_flush_cnt <= FLUSH_LOAD;
                  r_pix_cnt   <= '0;
                  r_status    <= ST_OK;
               end
            end

            FLUSH: begin
               if (capture_abort) begin
                  r_state  <= DONE;
                  r_sreset <= 1'b0;
                  r_done   <= 1'b1;
                  r_status <= ST_ABORT;
               end else if (r_flush_cnt == '0) begin
                  r_state  <= SYNC;
                  r_sreset <= 1'b0;
                  r_ready  <= 1'b1;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 1'b1;
               end
            end

            SYNC, CAPTURE: begin
               // Priority: abort, then EOP completion, then watchdog, then counting.
               if (capture_abort) begin
                  r_state  <= DONE;
                  r_ready  <= 1'b0;
                  r_done   <= 1'b1;
                  r_status <= ST_ABORT;
               end else if (w_end) begin
                  r_state   <= DONE;
                  r_ready   <= 1'b0;
                  r_done    <= 1'b1;
                  r_pix_cnt <= w_pix_new;
                  r_status  <= eop_status(w_size_err);
                  if (!w_size_err) begin
                     r_frm_cnt <= r_frm_cnt + 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state  <= DONE;
                  r_ready  <= 1'b0;
                  r_done   <= 1'b1;
                  r_status <= ST_TIMEOUT;
               end else if (w_take) begin
                  r_pix_cnt <= w_pix_new;
                  r_state   <= CAPTURE;
                  if (w_restart) begin
                     r_status <= ST_SIZE;
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state  <= IDLE;
               r_ready  <= 1'b0;
               r_sreset <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign stream_control_ready  = r_ready;
   assign stream_control_sreset = r_sreset;
   assign capture_busy          = r_busy;
   assign capture_done          = r_done;
   assign capture_status        = r_status;
   assign pixel_count           = r_pix_cnt;
   assign frame_count           = r_frm_cnt;

endmodule

// File: tb/tb_video_frame_capture_ctrl.sv
// Directed bench for video_frame_capture_ctrl; frame length is scaled down to keep
// runs short. Define VFCC_TIMEOUT_EN to add the watchdog scenario.
module tb_video_frame_capture_ctrl;

   localparam int FP  = 1000;
   localparam int PCW = 24;
   localparam int FCW = 16;

   logic           clk_clk = 1'b0;
   logic           reset_reset_n = 1'b0;
   logic           capture_req = 1'b0;
   logic           capture_abort = 1'b0;
   logic           stream_valid = 1'b0;
   logic           stream_startofpacket = 1'b0;
   logic           stream_control_endofpacket = 1'b0;
   logic           stream_control_ready;
   logic           stream_control_sreset;
   logic           capture_busy;
   logic           capture_done;
   logic [1:0]     capture_status;
   logic [PCW-1:0] pixel_count;
   logic [FCW-1:0] frame_count;

   int n_tests = 0;
   int n_fail  = 0;

   video_frame_capture_ctrl #(
      .FRAME_PIXELS  (FP),
      .PIX_CNT_W     (PCW),
      .SRESET_CYCLES (4),
      .FRM_CNT_W     (FCW)
`ifdef VFCC_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(1000)
`endif
   ) dut (
      .clk_clk                    (clk_clk),
      .reset_reset_n              (reset_reset_n),
      .capture_req                (capture_req),
      .capture_abort              (capture_abort),
      .stream_valid               (stream_valid),
      .stream_startofpacket       (stream_startofpacket),
      .stream_control_endofpacket (stream_control_endofpacket),
      .stream_control_ready       (stream_control_ready),
      .stream_control_sreset      (stream_control_sreset),
      .capture_busy               (capture_busy),
      .capture_done               (capture_done),
      .capture_status             (capture_status),
      .pixel_count                (pixel_count),
      .frame_count                (frame_count)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_clk);
      #1;
   endtask

   task automatic beat(input logic sop, input logic eop);
      stream_valid = 1'b1;
      stream_startofpacket = sop;
      stream_control_endofpacket = eop;
      tick();
      stream_startofpacket = 1'b0;
      stream_control_endofpacket = 1'b0;
   endtask

   task automatic mids(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0);
   endtask

   task automatic idle_stream;
      stream_valid = 1'b0;
      stream_startofpacket = 1'b0;
      stream_control_endofpacket = 1'b0;
   endtask

   task automatic start_capture(input string tag);
      int n;
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      chk({tag, "_pix_clr"}, pixel_count, 0);
      chk({tag, "_stat_clr"}, capture_status, 0);
      n = 0;
      while (!stream_control_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, stream_control_ready, 1);
   endtask

   initial begin
      int n;

      // Reset state
      #12;
      chk("rst_ready", stream_control_ready, 0);
      chk("rst_sreset", stream_control_sreset, 0);
      chk("rst_busy", capture_busy, 0);
      chk("rst_done", capture_done, 0);
      chk("rst_status", capture_status, 0);
      chk("rst_pix", pixel_count, 0);
      chk("rst_frm", frame_count, 0);
      tick();
      reset_reset_n = 1'b1;
      tick();

      // Flush length and SYNC discard, then a nominal frame
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      chk("flush_busy", capture_busy, 1);
      chk("flush_ready_lo", stream_control_ready, 0);
      n = 0;
      while (stream_control_sreset && n < 20) begin
         n++;
         tick();
      end
      chk("flush_len", n, 4);
      chk("sync_ready", stream_control_ready, 1);
      mids(10);
      chk("sync_discard_pix", pixel_count, 0);
      chk("sync_no_done", capture_done, 0);
      beat(1'b1, 1'b0);
      chk("sop_pix1", pixel_count, 1);
      mids(FP - 2);
      beat(1'b0, 1'b1);
      idle_stream();
      chk("nom_done", capture_done, 1);
      chk("nom_status", capture_status, 0);
      chk("nom_pix", pixel_count, FP);
      chk("nom_frm", frame_count, 1);
      chk("nom_ready_lo", stream_control_ready, 0);
      tick();
      chk("nom_done_pulse", capture_done, 0);
      chk("nom_idle", capture_busy, 0);
      chk("nom_pix_hold", pixel_count, FP);
      $display("[TB] nominal frame: status=%0d pix=%0d frames=%0d", capture_status, pixel_count, frame_count);

      // Short frame: EOP at beat 100
      start_capture("short");
      beat(1'b1, 1'b0);
      mids(98);
      beat(1'b0, 1'b1);
      idle_stream();
      chk("short_done", capture_done, 1);
      chk("short_status", capture_status, 1);
      chk("short_pix", pixel_count, 100);
      chk("short_frm", frame_count, 1);
      tick();
      $display("[TB] short frame: status=%0d pix=%0d", capture_status, pixel_count);

      // Extra SOP at beat 50, then exactly FP beats from the restart
      start_capture("xsop");
      beat(1'b1, 1'b0);
      mids(48);
      beat(1'b1, 1'b0);
      chk("xsop_restart", pixel_count, 1);
      chk("xsop_latched", capture_status, 1);
      mids(FP - 2);
      beat(1'b0, 1'b1);
      idle_stream();
      chk("xsop_done", capture_done, 1);
      chk("xsop_status", capture_status, 1);
      chk("xsop_pix", pixel_count, FP);
      chk("xsop_frm", frame_count, 1);
      tick();
      $display("[TB] extra SOP: status=%0d pix=%0d", capture_status, pixel_count);

      // Abort on beat 500
      start_capture("abort");
      beat(1'b1, 1'b0);
      mids(498);
      capture_abort = 1'b1;
      beat(1'b0, 1'b0);
      capture_abort = 1'b0;
      idle_stream();
      chk("abort_done", capture_done, 1);
      chk("abort_status", capture_status, 2);
      chk("abort_ready", stream_control_ready, 0);
      chk("abort_pix", pixel_count, 499);
      chk("abort_frm", frame_count, 1);
      tick();
      $display("[TB] abort: status=%0d pix=%0d", capture_status, pixel_count);

      // Abort coincident with EOP
      start_capture("abeop");
      beat(1'b1, 1'b0);
      mids(8);
      capture_abort = 1'b1;
      beat(1'b0, 1'b1);
      capture_abort = 1'b0;
      idle_stream();
      chk("abeop_done", capture_done, 1);
      chk("abeop_status", capture_status, 2);
      chk("abeop_frm", frame_count, 1);
      tick();

      // Abort while idle is ignored
      capture_abort = 1'b1;
      tick();
      capture_abort = 1'b0;
      chk("idle_abort_busy", capture_busy, 0);
      chk("idle_abort_done", capture_done, 0);
      $display("[TB] abort with EOP / idle abort: status=%0d busy=%0d", capture_status, capture_busy);

      // Abort during flush drops sreset on the next edge
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      capture_abort = 1'b1;
      tick();
      capture_abort = 1'b0;
      chk("fabort_sreset", stream_control_sreset, 0);
      chk("fabort_done", capture_done, 1);
      chk("fabort_status", capture_status, 2);
      tick();
      $display("[TB] flush abort: status=%0d", capture_status);

      // Good frame with capture_req held through DONE: request is not taken in DONE
      start_capture("good2");
      beat(1'b1, 1'b0);
      mids(FP - 2);
      capture_req = 1'b1;
      beat(1'b0, 1'b1);
      idle_stream();
      chk("good2_done", capture_done, 1);
      chk("good2_frm", frame_count, 2);
      tick();
      capture_req = 1'b0;
      chk("done_req_ignored", capture_busy, 0);
      tick();
      chk("done_req_still_idle", stream_control_sreset, 0);
      $display("[TB] second frame: status=%0d frames=%0d", capture_status, frame_count);

`ifdef VFCC_TIMEOUT_EN
      // Watchdog: no SOP ever arrives
      start_capture("tmo");
      n = 0;
      while (!capture_done && n < 2000) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, 1000);
      chk("tmo_status", capture_status, 3);
      tick();
      $display("[TB] timeout: cycles=%0d status=%0d", n, capture_status);
`endif

      // Asynchronous reset in the middle of a frame
      start_capture("arst");
      beat(1'b1, 1'b0);
      mids(20);
      #2;
      reset_reset_n = 1'b0;
      #1;
      chk("arst_ready", stream_control_ready, 0);
      chk("arst_busy", capture_busy, 0);
      chk("arst_pix", pixel_count, 0);
      chk("arst_frm", frame_count, 0);
      chk("arst_status", capture_status, 0);
      idle_stream();
      tick();
      reset_reset_n = 1'b1;
      tick();
      $display("[TB] async reset: busy=%0d pix=%0d frames=%0d", capture_busy, pixel_count, frame_count);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
